// File: rtl/npu_mac_addertree_if.sv
// Operand/result bundle of one NPU processing-element MAC.
//   mcand_i     : 9 x signed int8 multiplicands, lane k = [8k+7:8k]
//   mplier_i    : 9 x signed int8 multipliers,   lane k = [8k+7:8k]
//   bias_i      : signed 16-bit bias, weight 2^0
//   in_valid_i  : operands valid this cycle
//   acc_first_i : first partial sum of a window (feedback forced to 0)
//   out_o       : signed 13-bit saturated result (registered)
//   out_valid_o : out_o updated this cycle
// master = operand source, slave = MAC core.
interface npu_mac_addertree_if;
  logic [71:0] mcand_i;
  logic [71:0] mplier_i;
  logic [15:0] bias_i;
  logic        in_valid_i;
  logic        acc_first_i;
  logic [12:0] out_o;
  logic        out_valid_o;

  modport master (
    output mcand_i, mplier_i, bias_i, in_valid_i, acc_first_i,
    input  out_o, out_valid_o
  );

  modport slave (
    input  mcand_i, mplier_i, bias_i, in_valid_i, acc_first_i,
    output out_o, out_valid_o
  );
endinterface

// File: rtl/npu_mac_addertree.sv
// 9-lane signed int8 multiply-accumulate core of one NPU processing element
// (3x3 convolution window).
//   stage 1 : sum of the 9 signed 8x8 products plus the 16-bit bias
//   stage 2 : adds the feedback term (previous clipped output << 6)
//   The 20-bit sum is saturated to a 13-bit signed activation taken from
//   sum bits [18:6] and registered (latency 1 clock).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : operand/result bundle (slave side), see npu_mac_addertree_if
module npu_mac_addertree (
  input logic                  clk,
  input logic                  reset,
  npu_mac_addertree_if.slave   bus
);

  localparam int LANES = 9;
  localparam int DW    = 8;
  localparam int OW    = 13;
  localparam int SW    = 20;

  logic [DW-1:0]   lane_a;
  logic [DW-1:0]   lane_b;
  logic [2*DW-1:0] lane_prod;
  logic [SW-1:0]   stage1_sum;
  logic [SW-1:0]   stage2_sum;
  logic [OW-1:0]   fb;
  logic [OW-1:0]   clipped;
  logic [OW-1:0]   out_q;
  logic            out_valid_q;

  // Stage 1: products and bias. Operands are sign-extended to 16 bits, so
  // the low 16 bits of the product are the exact signed result
  // (-128 * -128 = +16384 still fits).
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    lane_a     = '0;
    lane_b     = '0;
    lane_prod  = '0;
    // NOTE: blocking assignments here because the loop accumulates into
    // stage1_sum combinationally, one lane after another.
    stage1_sum = {{(SW-16){bus.bias_i[15]}}, bus.bias_i};
    for (int k = 0; k < LANES; k++) begin
      lane_a     = bus.mcand_i[k*DW +: DW];
      lane_b     = bus.mplier_i[k*DW +: DW];
      lane_prod  = {{DW{lane_a[DW-1]}}, lane_a} * {{DW{lane_b[DW-1]}}, lane_b};
      stage1_sum = stage1_sum + {{(SW-2*DW){lane_prod[2*DW-1]}}, lane_prod};
    end
  end

  // Stage 2: feedback is always the saturated registered output, aligned
  // to weight 2^6 so it lines up with the output LSB.
  assign fb         = bus.acc_first_i ? '0 : out_q;
  assign stage2_sum = stage1_sum + {fb[OW-1], fb, 6'b0};

  // The 20-bit sum cannot wrap, so bits [19:18] disagreeing means the
  // value lies outside the 13-bit output range after the >> 6.
  always_comb begin
    case (stage2_sum[SW-1:SW-2])
      2'b01:   clipped = 13'h0FFF;   // +4095
      2'b10:   clipped = 13'h1000;   // -4096
      default: clipped = stage2_sum[18:6];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        out_q <= clipped;
      end
    end
  end

  assign bus.out_o       = out_q;
  assign bus.out_valid_o = out_valid_q;

endmodule

// File: tb/tb_npu_mac_addertree.sv
module tb_npu_mac_addertree;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   model_fb;

  npu_mac_addertree_if bus ();

  npu_mac_addertree dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clip(input int s);
    if (s > 262143)  return 4095;
    if (s < -262144) return -4096;
    return s >>> 6;
  endfunction

  function automatic int out_val();
    logic signed [12:0] o;
    o = bus.out_o;
    return int'(o);
  endfunction

  // Same operand pair on every lane.
  task automatic set_all(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] bias, input logic first,
                         input logic valid);
    for (int k = 0; k < 9; k++) begin
      bus.mcand_i[k*8 +: 8]  = a;
      bus.mplier_i[k*8 +: 8] = b;
    end
    bus.bias_i      = bias;
    bus.acc_first_i = first;
    bus.in_valid_i  = valid;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int exp_out,
                            input logic exp_valid);
    checks++;
    if (out_val() !== exp_out || bus.out_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL %s: out=%0d valid=%0b, expected out=%0d valid=%0b",
               name, out_val(), bus.out_valid_o, exp_out, exp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_all(8'd0, 8'd0, 16'd0, 1'b1, 1'b0);
    #1;
    expect_out("reset_state", 0, 1'b0);
    step();
    reset = 1'b0;
    // Build up state, then reset mid-cycle while in_valid_i is high.
    set_all(8'd127, 8'd127, 16'sd32767, 1'b1, 1'b1);
    step();
    expect_out("pre_reset_build", 2780, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("reset_mid_run", 0, 1'b0);
    step();
    expect_out("reset_held_over_edge", 0, 1'b0);
    reset = 1'b0;
    // acc_first=0 after reset: feedback register must be cleared.
    set_all(8'd3, 8'd5, 16'd0, 1'b0, 1'b1);
    step();
    expect_out("post_reset_fb_zero", 2, 1'b1);
    set_all(8'd3, 8'd5, 16'd0, 1'b1, 1'b1);
    step();
    expect_out("post_reset_first", 2, 1'b1);
  endtask

  task automatic test_basic();
    set_all(8'd3, 8'd5, 16'd0, 1'b1, 1'b1);
    step();
    expect_out("basic_3x5", 2, 1'b1);
    // 135 + 2*64 = 263 -> 4
    set_all(8'd3, 8'd5, 16'd0, 1'b0, 1'b1);
    step();
    expect_out("basic_accum", 4, 1'b1);
  endtask

  task automatic test_hold();
    set_all(8'd100, 8'd100, 16'd0, 1'b0, 1'b0);
    step();
    expect_out("hold_invalid", 4, 1'b0);
    step();
    expect_out("hold_invalid_2", 4, 1'b0);
    // Feedback unchanged by idle cycles: 135 + 4*64 = 391 -> 6
    set_all(8'd3, 8'd5, 16'd0, 1'b0, 1'b1);
    step();
    expect_out("hold_then_accum", 6, 1'b1);
  endtask

  task automatic test_pos_sat();
    set_all(8'd127, 8'd127, 16'sd32767, 1'b1, 1'b1);
    step();
    expect_out("pos_first", 2780, 1'b1);
    set_all(8'd127, 8'd127, 16'sd32767, 1'b0, 1'b1);
    step();
    expect_out("pos_saturate", 4095, 1'b1);
    // Feedback uses the clipped 4095: 177928 + 262080 = 440008 -> 4095
    step();
    expect_out("pos_saturate_hold", 4095, 1'b1);
  endtask

  task automatic test_neg_sat();
    set_all(8'h80, 8'd127, 16'h8000, 1'b1, 1'b1);
    step();
    expect_out("neg_first", -2798, 1'b1);
    set_all(8'h80, 8'd127, 16'h8000, 1'b0, 1'b1);
    step();
    expect_out("neg_saturate", -4096, 1'b1);
    // -128 * -128 corner: 9*16384 = 147456 -> 2304
    set_all(8'h80, 8'h80, 16'd0, 1'b1, 1'b1);
    step();
    expect_out("min_times_min", 2304, 1'b1);
    // -1 bias floors to -1: S = -1 -> out = -1
    set_all(8'd0, 8'd0, 16'hFFFF, 1'b1, 1'b1);
    step();
    expect_out("floor_round", -1, 1'b1);
  endtask

  // Apply one vector with arbitrary per-lane operands and check against the
  // exact reference within tolerance.
  task automatic apply_and_check(input string name, input logic [71:0] a_v,
                                 input logic [71:0] b_v, input logic [15:0] bias,
                                 input logic first);
    int s;
    int exp_out;
    int diff;
    logic signed [7:0]  sa;
    logic signed [7:0]  sb;
    logic signed [15:0] sbias;
    bus.mcand_i     = a_v;
    bus.mplier_i    = b_v;
    bus.bias_i      = bias;
    bus.acc_first_i = first;
    bus.in_valid_i  = 1'b1;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      sa = a_v[k*8 +: 8];
      sb = b_v[k*8 +: 8];
      s += int'(sa) * int'(sb);
    end
    sbias = bias;
    s += int'(sbias);
    if (!first) s += model_fb * 64;
    exp_out  = clip(s);
    model_fb = exp_out;
    step();
    diff = out_val() - exp_out;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > 16 || bus.out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: out=%0d valid=%0b, expected %0d (+-16) valid=1",
               name, out_val(), bus.out_valid_o, exp_out);
    end
  endtask

  task automatic test_random_cadence();
    logic [71:0] a_v;
    logic [71:0] b_v;
    logic [15:0] bias;
    model_fb = 0;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 9; k++) begin
        a_v[k*8 +: 8] = 8'($urandom);
        b_v[k*8 +: 8] = 8'($urandom);
      end
      bias = 16'($urandom);
      apply_and_check("random_cadence", a_v, b_v, bias, (i % 4) == 0);
    end
  endtask

  task automatic test_sweep();
    logic [71:0] a_v;
    logic [71:0] b_v;
    logic [15:0] bias;
    int idx;
    idx = 0;
    model_fb = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        for (int k = 0; k < 9; k++) begin
          a_v[k*8 +: 8] = 8'(a);
          b_v[k*8 +: 8] = 8'(b);
        end
        bias = 16'(idx * 5);
        apply_and_check("sweep", a_v, b_v, bias, (idx % 4) == 0);
        idx++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    model_fb = 0;
    test_reset();
    test_basic();
    test_hold();
    test_pos_sat();
    test_neg_sat();
    test_random_cadence();
    test_sweep();
    bus.in_valid_i = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
